// File: rtl/tcbm_drive_port.sv
// TCBM paddle-link responder, 1551 drive end.
// Decodes command/data pairs over DAV/ACK and bridges them to rx/tx streams.
module tcbm_drive_port #(
  parameter int TIMEOUT     = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic [7:0] tcbm_data_in,
  output logic [7:0] tcbm_data_out,
  output logic       tcbm_data_oe,
  input  logic       tcbm_dav,
  output logic       tcbm_ack,
  output logic [1:0] tcbm_st,
  output logic [7:0] rx_data,
  output logic       rx_is_cmd,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       err_bad_cmd
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_ACK, DATA_WAIT, W_HOLD, R_WAIT, DATA_ACK
  } state_t;

  typedef enum logic [1:0] {
    M_NONE, M_WR, M_RD, M_CMD
  } mode_t;

  state_t  state;
  mode_t   mode;
  mode_t   dec;
  logic [TW-1:0] timer;

  logic [SYNC_STAGES-1:0]      dav_q;
  logic [SYNC_STAGES-1:0][7:0] data_q;
  logic       dav_s;
  logic [7:0] data_s;
  logic       rx_hs;
  logic       tx_hs;
  logic       t_out;

  // Idle bus reads DAV high, so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      dav_q  <= '1;
      data_q <= '0;
    end else begin
      dav_q[0]  <= tcbm_dav;
      data_q[0] <= tcbm_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dav_q[i]  <= dav_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign dav_s  = dav_q[SYNC_STAGES-1];
  assign data_s = data_q[SYNC_STAGES-1];
  assign rx_hs  = rx_valid && rx_ready;
  assign tx_hs  = tx_valid && tx_ready;
  assign t_out  = (timer == T_LAST);

  always_comb begin
    dec = M_NONE;
    unique case (data_s)
      8'h81:   dec = M_WR;
      8'h82:   dec = M_RD;
      8'h83:   dec = M_CMD;
      default: dec = M_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state         <= IDLE;
      mode          <= M_NONE;
      timer         <= '0;
      tcbm_ack      <= 1'b1;
      tcbm_st       <= 2'b00;
      tcbm_data_oe  <= 1'b0;
      tcbm_data_out <= 8'h00;
      rx_valid      <= 1'b0;
      rx_data       <= 8'h00;
      rx_is_cmd     <= 1'b0;
      tx_ready      <= 1'b0;
      err_bad_cmd   <= 1'b0;
    end else begin
      err_bad_cmd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!dav_s) begin
            mode        <= dec;
            err_bad_cmd <= (dec == M_NONE);
            tcbm_ack    <= 1'b0;
            state       <= CMD_ACK;
          end
        end
        CMD_ACK: begin
          if (dav_s) begin
            tcbm_ack <= 1'b1;
            state    <= (mode == M_NONE) ? IDLE : DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          if (!dav_s) begin
            timer <= '0;
            if (mode == M_RD) begin
              tx_ready <= 1'b1;
              state    <= R_WAIT;
            end else begin
              rx_data   <= data_s;
              rx_is_cmd <= (mode == M_CMD);
              rx_valid  <= 1'b1;
              state     <= W_HOLD;
            end
          end
        end
        W_HOLD: begin
          // A handshake beats both abort and timeout on the same cycle.
          if (rx_hs) begin
            rx_valid <= 1'b0;
            if (dav_s) begin
              state <= IDLE;
            end else begin
              tcbm_st  <= 2'b00;
              tcbm_ack <= 1'b0;
              state    <= DATA_ACK;
            end
          end else if (dav_s) begin
            rx_valid <= 1'b0;
            state    <= IDLE;
          end else if (t_out) begin
            rx_valid <= 1'b0;
            tcbm_st  <= 2'b01;
            tcbm_ack <= 1'b0;
            state    <= DATA_ACK;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        R_WAIT: begin
          if (tx_hs) begin
            tx_ready <= 1'b0;
            if (dav_s) begin
              state <= IDLE;
            end else begin
              tcbm_data_out <= tx_data;
              tcbm_data_oe  <= 1'b1;
              tcbm_st       <= tx_eoi ? 2'b11 : 2'b00;
              tcbm_ack      <= 1'b0;
              state         <= DATA_ACK;
            end
          end else if (dav_s) begin
            tx_ready <= 1'b0;
            state    <= IDLE;
          end else if (t_out) begin
            tx_ready      <= 1'b0;
            tcbm_data_out <= 8'h00;
            tcbm_data_oe  <= 1'b1;
            tcbm_st       <= 2'b01;
            tcbm_ack      <= 1'b0;
            state         <= DATA_ACK;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA_ACK: begin
          if (dav_s) begin
            tcbm_ack     <= 1'b1;
            tcbm_data_oe <= 1'b0;
            tcbm_st      <= 2'b00;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
